// File: rtl/vga_scanout_pkg.sv
// Shared timing constants, framebuffer geometry and small helpers for the VGA scan-out.
package vga_scanout_pkg;
  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned FB_WIDTH  = 320;
  localparam int unsigned FB_HEIGHT = 240;
  localparam int unsigned FB_ADDR_W = 17;
  localparam int unsigned FB_DEPTH  = FB_WIDTH * FB_HEIGHT;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  // Sync/blank flags travelling alongside a pixel; hs/vs held in their active-low form.
  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
  } sync_t;

  function automatic fb_addr_t fb_addr(input logic [8:0] x, input logic [8:0] y);
    return fb_addr_t'(y) * fb_addr_t'(FB_WIDTH) + fb_addr_t'(x);
  endfunction

  function automatic logic [7:0] expand(input logic bit_on);
    return bit_on ? 8'hFF : 8'h00;
  endfunction
endpackage

// File: rtl/vga_scanout_fb_ram.sv
// 320x240 x 3-bit framebuffer: write port A, registered read port B, old data on read-during-write.
module fb_ram
  import vga_scanout_pkg::*;
(
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [FB_ADDR_W-1:0] wr_addr,
  input  logic [2:0]           wr_data,
  input  logic                 rd_en,
  input  logic [FB_ADDR_W-1:0] rd_addr,
  output logic [2:0]           rd_data
);
  logic [2:0] mem [FB_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/vga_scanout.sv
// 640x480 VGA scan-out of a pixel-doubled 320x240 3-bit framebuffer, with a write port
// for the drawing blocks. Timing is parameterised so reduced geometries can be exercised.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int unsigned HVIS = H_VISIBLE,
  parameter int unsigned HFP  = H_FRONT,
  parameter int unsigned HSW  = H_SYNC,
  parameter int unsigned HBP  = H_BACK,
  parameter int unsigned VVIS = V_VISIBLE,
  parameter int unsigned VFP  = V_FRONT,
  parameter int unsigned VSW  = V_SYNC,
  parameter int unsigned VBP  = V_BACK
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       plot,
  input  logic [8:0] xLoc,
  input  logic [8:0] yLoc,
  input  logic [2:0] colour,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vga_clk,
  output logic       frame_start,
  output logic       wr_drop
);
  localparam logic [9:0] H_VIS_END = 10'(HVIS);
  localparam logic [9:0] HS_BEGIN  = 10'(HVIS + HFP);
  localparam logic [9:0] HS_END    = 10'(HVIS + HFP + HSW);
  localparam logic [9:0] H_LAST    = 10'(HVIS + HFP + HSW + HBP - 1);
  localparam logic [9:0] V_VIS_END = 10'(VVIS);
  localparam logic [9:0] VS_BEGIN  = 10'(VVIS + VFP);
  localparam logic [9:0] VS_END    = 10'(VVIS + VFP + VSW);
  localparam logic [9:0] V_LAST    = 10'(VVIS + VFP + VSW + VBP - 1);

  logic                 pix_en;
  logic [9:0]           hcount;
  logic [9:0]           vcount;
  logic                 visible;
  logic                 in_range;
  logic                 wr_en;
  logic                 rd_en;
  logic [FB_ADDR_W-1:0] wr_addr;
  logic [FB_ADDR_W-1:0] rd_addr;
  logic [2:0]           rd_data;
  sync_t                s1;

  assign visible    = (hcount < H_VIS_END) && (vcount < V_VIS_END);
  assign in_range   = (xLoc < 9'(FB_WIDTH)) && (yLoc < 9'(FB_HEIGHT));
  assign wr_en      = resetn && plot && in_range;
  assign wr_addr    = fb_addr(xLoc, yLoc);
  assign rd_en      = pix_en && visible;
  assign rd_addr    = fb_addr(hcount[9:1], vcount[9:1]);
  assign vga_sync_n = 1'b0;
  assign vga_clk    = pix_en;

  // frame_start is set on the idle half-tick that follows the wrap to (0,0), so it is high
  // exactly during the pix_en tick at the origin, including the first tick after reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pix_en      <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= ~pix_en;
      frame_start <= ~pix_en && (hcount == '0) && (vcount == '0);
      if (pix_en) begin
        hcount <= (hcount == H_LAST) ? '0 : hcount + 10'd1;
        if (hcount == H_LAST) vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
      end
    end
  end

  fb_ram u_fb_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (colour),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Stage 1 runs in step with the RAM read so flags and data meet at the output register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1 <= '{hs: 1'b1, vs: 1'b1, vis: 1'b0};
    end else if (pix_en) begin
      s1.hs  <= !((hcount >= HS_BEGIN) && (hcount < HS_END));
      s1.vs  <= !((vcount >= VS_BEGIN) && (vcount < VS_END));
      s1.vis <= visible;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
    end else if (pix_en) begin
      vga_hs      <= s1.hs;
      vga_vs      <= s1.vs;
      vga_blank_n <= s1.vis;
      vga_r       <= expand(s1.vis && rd_data[2]);
      vga_g       <= expand(s1.vis && rd_data[1]);
      vga_b       <= expand(s1.vis && rd_data[0]);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) wr_drop <= 1'b0;
    else if (plot && !in_range) wr_drop <= 1'b1;
  end
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a reduced-geometry instance checked every clk against a pixel-index
// model, plus a full-timing instance for line timing and reset values.
`timescale 1ns/1ps
module tb_vga_scanout;
  localparam int HV = 16, HF = 2, HS = 4, HB = 2, HT = HV + HF + HS + HB;
  localparam int VV = 8,  VF = 1, VS = 2, VB = 1, VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int FBW = 320, FBH = 240;
  localparam int LIMIT = 5000;

  logic       clk = 1'b0, resetn = 1'b0, plot = 1'b0;
  logic [8:0] xLoc = '0, yLoc = '0;
  logic [2:0] colour = '0;
  logic [7:0] vga_r, vga_g, vga_b, r_b, g_b, b_b;
  logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_start, wr_drop;
  logic       hs_b, vs_b, blank_n_b, sync_n_b, vclk_b, fs_b, drop_b;

  always #10 clk = ~clk;

  vga_scanout #(.HVIS(HV), .HFP(HF), .HSW(HS), .HBP(HB),
                .VVIS(VV), .VFP(VF), .VSW(VS), .VBP(VB)) dut (
    .clk(clk), .resetn(resetn), .plot(plot), .xLoc(xLoc), .yLoc(yLoc), .colour(colour),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n), .vga_clk(vga_clk),
    .frame_start(frame_start), .wr_drop(wr_drop));

  vga_scanout dut_full (
    .clk(clk), .resetn(resetn), .plot(plot), .xLoc(xLoc), .yLoc(yLoc), .colour(colour),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_hs(hs_b), .vga_vs(vs_b),
    .vga_blank_n(blank_n_b), .vga_sync_n(sync_n_b), .vga_clk(vclk_b),
    .frame_start(fs_b), .wr_drop(drop_b));

  typedef struct { logic hs; logic vs; logic blank_n; logic [23:0] rgb; bit known; } pix_t;
  typedef struct { int x; int y; logic [2:0] c; bit drop; } wv_t;

  int n_cmp = 0, n_bad = 0;
  int rel_edges = 0;
  bit seen_reset = 0, exp_drop = 0;
  pix_t exp_q[$];
  pix_t cur;
  logic [2:0] fb_m [FBW*FBH];
  bit         fb_k [FBW*FBH];

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  task automatic timeout(string name);
    n_cmp++; n_bad++;
    $display("FAIL %s: event not seen within %0d clk", name, LIMIT);
  endtask

  function automatic logic [23:0] rgb_of(logic [2:0] c);
    return {c[2] ? 8'hFF : 8'h00, c[1] ? 8'hFF : 8'h00, c[0] ? 8'hFF : 8'h00};
  endfunction

  function automatic pix_t reset_pix();
    pix_t p;
    p.hs = 1'b1; p.vs = 1'b1; p.blank_n = 1'b0; p.rgb = '0; p.known = 1;
    return p;
  endfunction

  // Expected output for the n-th pixel slot after reset release, from the timing table.
  function automatic pix_t pixel_exp(int n);
    pix_t p;
    int h, v, a;
    h = n % HT;
    v = (n / HT) % VT;
    p.hs = !(h >= HV + HF && h < HV + HF + HS);
    p.vs = !(v >= VV + VF && v < VV + VF + VS);
    p.blank_n = (h < HV) && (v < VV);
    p.rgb = '0;
    p.known = 1;
    if (p.blank_n) begin
      a = (v / 2) * FBW + h / 2;
      p.known = fb_k[a];
      p.rgb = rgb_of(fb_m[a]);
    end
    return p;
  endfunction

  // Reference model: pixel n is fetched on released edge 2n+1 (before that edge's write lands).
  initial forever begin : model
    int k;
    @(posedge clk);
    if (!resetn) begin
      rel_edges = 0; seen_reset = 1; exp_drop = 0; exp_q.delete();
    end else begin
      k = rel_edges;
      if (k % 2 == 1) exp_q.push_back(pixel_exp((k - 1) / 2));
      rel_edges = rel_edges + 1;
      if (plot) begin
        if (xLoc < FBW && yLoc < FBH) begin
          fb_m[yLoc * FBW + xLoc] = colour;
          fb_k[yLoc * FBW + xLoc] = 1;
        end else exp_drop = 1;
      end
    end
  end

  task automatic check_cycle();
    int k;
    bit fs_e, vclk_e;
    pix_t e;
    logic [23:0] rgb_got;
    k = rel_edges - 1;
    fs_e = 0; vclk_e = 0;
    e = reset_pix();
    if (rel_edges > 0) begin
      vclk_e = (k % 2 == 0);
      fs_e = (k % 2 == 0) && ((k / 2) % FRAME == 0);
      if (k >= 3) begin
        if (k % 2 == 1) begin
          if (exp_q.size() == 0) timeout("model queue");
          else cur = exp_q.pop_front();
        end
        e = cur;
      end
    end
    rgb_got = {vga_r, vga_g, vga_b};
    if (!e.known) begin rgb_got = '0; e.rgb = '0; end
    check($sformatf("scan k=%0d", k),
          {vga_hs, vga_vs, vga_blank_n, rgb_got, frame_start, vga_clk, wr_drop, vga_sync_n},
          {e.hs, e.vs, e.blank_n, e.rgb, fs_e, vclk_e, exp_drop, 1'b0});
  endtask

  initial forever begin : monitor
    @(negedge clk);
    if (seen_reset) check_cycle();
  end

  task automatic wait_rel(int target, string name);
    int g = 0;
    while (rel_edges != target) begin
      @(negedge clk);
      g++;
      if (g > LIMIT) begin timeout(name); return; end
    end
  endtask

  function automatic logic sig(int w);
    case (w)
      0: return vga_hs;
      1: return vga_vs;
      2: return frame_start;
      3: return hs_b;
      default: return blank_n_b;
    endcase
  endfunction

  // Measures clk spent at lvl and the period between entries into lvl.
  task automatic measure(int w, logic lvl, string name, int want_act, int want_per);
    int g = 0, act = 0, per = 0;
    while (sig(w) == lvl) begin @(negedge clk); if (++g > LIMIT) begin timeout(name); return; end end
    while (sig(w) != lvl) begin @(negedge clk); if (++g > LIMIT) begin timeout(name); return; end end
    while (sig(w) == lvl) begin act++; @(negedge clk); if (act > LIMIT) begin timeout(name); return; end end
    per = act;
    while (sig(w) != lvl) begin per++; @(negedge clk); if (per > LIMIT) begin timeout(name); return; end end
    check({name, " active"}, act, want_act);
    check({name, " period"}, per, want_per);
  endtask

  task automatic show_at(int n, logic [23:0] want, logic want_blank_n, string name);
    wait_rel(2 * n + 4, name);
    check({name, " rgb"}, {vga_r, vga_g, vga_b}, want);
    check({name, " blank_n"}, vga_blank_n, want_blank_n);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: run did not reach its summary in 2 ms");
    $fatal(1);
  end

  initial begin : stim
    wv_t tbl [9];
    int n0, n, g;
    tbl[0] = '{x: 0,   y: 0,   c: 3'b100, drop: 0};
    tbl[1] = '{x: 319, y: 239, c: 3'b011, drop: 0};
    tbl[2] = '{x: 7,   y: 3,   c: 3'b110, drop: 0};
    tbl[3] = '{x: 319, y: 0,   c: 3'b001, drop: 0};
    tbl[4] = '{x: 320, y: 5,   c: 3'b111, drop: 1};
    tbl[5] = '{x: 320, y: 0,   c: 3'b111, drop: 1};
    tbl[6] = '{x: 0,   y: 240, c: 3'b111, drop: 1};
    tbl[7] = '{x: 320, y: 1,   c: 3'b111, drop: 1};
    tbl[8] = '{x: 1,   y: 1,   c: 3'b010, drop: 1};

    repeat (3) @(negedge clk);
    check("full reset sync/blank", {hs_b, vs_b, blank_n_b, fs_b, drop_b, vclk_b, sync_n_b},
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    resetn = 1'b1;

    for (int y = 0; y < 4; y++)
      for (int x = 0; x < FBW; x++) begin
        plot = 1'b1; xLoc = 9'(x); yLoc = 9'(y); colour = 3'((x + y) % 8);
        @(negedge clk);
      end
    plot = 1'b0;

    for (int i = 0; i < 9; i++) begin
      plot = 1'b1; xLoc = 9'(tbl[i].x); yLoc = 9'(tbl[i].y); colour = tbl[i].c;
      @(negedge clk);
      plot = 1'b0;
      check($sformatf("wr_drop row %0d", i), wr_drop, tbl[i].drop);
    end

    n0 = ((rel_edges / 2) / FRAME + 1) * FRAME;
    show_at(n0 - 1, 24'h000000, 1'b0, "blank before origin");
    show_at(n0, 24'hFF0000, 1'b1, "origin (0,0)");
    show_at(n0 + 1, 24'hFF0000, 1'b1, "origin (1,0)");
    show_at(n0 + HT, 24'hFF0000, 1'b1, "origin (0,1)");
    show_at(n0 + HT + 1, 24'hFF0000, 1'b1, "origin (1,1)");
    show_at(n0 + 7 * HT + 15, 24'hFFFF00, 1'b1, "corner (15,7)");

    measure(2, 1'b1, "frame_start", 1, 2 * FRAME);
    measure(2, 1'b1, "frame_start 2nd", 1, 2 * FRAME);
    measure(1, 1'b0, "vs", 2 * VS * HT, 2 * FRAME);
    measure(0, 1'b0, "hs", 2 * HS, 2 * HT);
    measure(3, 1'b0, "full hs", 192, 1600);
    measure(4, 1'b1, "full blank_n", 1280, 1600);

    plot = 1'b1; xLoc = 9'd2; yLoc = 9'd1; colour = 3'b010;
    @(negedge clk);
    plot = 1'b0;
    n = ((rel_edges / 2) / FRAME + 1) * FRAME + 2 * HT + 4;
    wait_rel(2 * n + 1, "rdw write slot");
    plot = 1'b1; xLoc = 9'd2; yLoc = 9'd1; colour = 3'b101;
    @(negedge clk);
    plot = 1'b0;
    show_at(n, 24'h00FF00, 1'b1, "rdw same frame");
    show_at(n + FRAME, 24'hFF00FF, 1'b1, "rdw next frame");

    for (int i = 0; i < 3 * 2 * FRAME; i++) begin
      plot = 1'($urandom_range(0, 1));
      xLoc = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(320, 511)) : 9'($urandom_range(0, 11));
      yLoc = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(240, 511)) : 9'($urandom_range(0, 4));
      colour = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    plot = 1'b0;

    g = 0;
    while (((rel_edges / 2) % FRAME) / HT != 5 && g <= LIMIT) begin @(negedge clk); g++; end
    if (g > LIMIT) timeout("reach line 5");
    resetn = 1'b0;
    plot = 1'b1; xLoc = 9'd0; yLoc = 9'd0; colour = 3'b001;
    repeat (3) @(negedge clk);
    plot = 1'b0;
    check("mid reset outputs", {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, frame_start, wr_drop},
          {1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0});
    check("mid reset full outputs", {hs_b, vs_b, blank_n_b, r_b, g_b, b_b, drop_b},
          {1'b1, 1'b1, 1'b0, 24'h0, 1'b0});
    resetn = 1'b1;
    @(negedge clk);
    check("first tick after release", {frame_start, vga_clk}, 2'b11);
    repeat (4 * FRAME + 8) @(negedge clk);
    check("wr_drop after reset", wr_drop, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
